// File: rtl/icache_fill.sv
// Direct-mapped instruction cache (one 32-bit word per line) with a single
// outstanding refill. Optional hit/miss counters are enabled by ICACHE_STAT_EN.
module icache_fill #(
  parameter int unsigned INDEX_WIDTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic        if_hit,
  output logic [31:0] if_inst,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_enable,
  input  logic [31:0] mem_din
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned LINES = 1 << INDEX_WIDTH;
  localparam int unsigned TAG_W = 16 - INDEX_WIDTH;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                   state;
  logic                     cancel;
  logic [LINES-1:0]         valid;
  logic [31:0]              data_mem [LINES];
  logic [TAG_W-1:0]         tag_mem  [LINES];

  logic [INDEX_WIDTH-1:0]   req_idx;
  logic [TAG_W-1:0]         req_tag;
  logic [INDEX_WIDTH-1:0]   fill_idx;
  logic [TAG_W-1:0]         fill_tag;
  logic                     lookup_hit;
  logic                     accept;
  logic                     fill;

  // Request decode comes from the fetch address, fill decode from the latched refill address.
  assign req_idx    = if_pc[INDEX_WIDTH+1:2];
  assign req_tag    = if_pc[17:INDEX_WIDTH+2];
  assign fill_idx   = mem_addr[INDEX_WIDTH+1:2];
  assign fill_tag   = mem_addr[17:INDEX_WIDTH+2];
  assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept     = rdy && (state == IDLE) && if_valid && !flush;
  assign fill       = rdy && (state == REFILL) && mem_enable;

  // Drops in the completion cycle so the controller never sees a second request.
  assign mem_valid  = (state == REFILL) && !mem_enable;

  // Data and tag storage carry no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[fill_idx] <= mem_din;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cancel   <= 1'b0;
      valid    <= '0;
      if_hit   <= 1'b0;
      if_inst  <= 32'h0;
      mem_addr <= 32'h0;
    end else begin
      if_hit <= 1'b0;
      if (rdy) begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              if (lookup_hit) begin
                if_hit  <= 1'b1;
                if_inst <= data_mem[req_idx];
              end else begin
                mem_addr <= if_pc & ~32'h3;
                cancel   <= 1'b0;
                state    <= REFILL;
              end
            end
          end
          REFILL: begin
            if (flush) cancel <= 1'b1;
            if (mem_enable) begin
              valid[fill_idx] <= 1'b1;
              state           <= IDLE;
              if (!cancel && !flush) begin
                if_hit  <= 1'b1;
                if_inst <= mem_din;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ICACHE_STAT_EN
  // Event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else if (accept) begin
      if (lookup_hit) hit_cnt  <= hit_cnt + 32'd1;
      else            miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fill.sv
// Randomized bench for icache_fill against a word-address cache model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_icache_fill;

  localparam int unsigned IW    = 6;
  localparam int unsigned LINES = 1 << IW;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        flush;
  logic        if_hit;
  logic [31:0] if_inst;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_enable;
  logic [31:0] mem_din;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_fill #(.INDEX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_valid(if_valid), .if_pc(if_pc), .flush(flush),
    .if_hit(if_hit), .if_inst(if_inst), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_enable(mem_enable), .mem_din(mem_din)
`ifdef ICACHE_STAT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Model: each line remembers which word address (pc[17:2]) it holds.
  bit          m_valid [LINES];
  logic [15:0] m_word  [LINES];
  logic [31:0] m_data  [LINES];
  logic [31:0] m_last;
  int          m_hits;
  int          m_misses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
    m_last   = 32'h0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check_stats(input string tag);
`ifdef ICACHE_STAT_EN
    check({tag, "_hits"}, hit_cnt, 32'(m_hits));
    check({tag, "_misses"}, miss_cnt, 32'(m_misses));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic do_pause(input logic [31:0] addr);
    rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("pause_addr", mem_addr, addr);
      check("pause_mv", 32'(mem_valid), 32'd1);
      check("pause_hit", 32'(if_hit), 32'd0);
    end
    rdy = 1'b1;
  endtask

  // One fetch from the falling edge: hit, or miss with refill after lat wait cycles.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] din, input int lat,
                       input int flush_at, input int pause_at);
    int          idx;
    bit          hit;
    bit          cancel;
    logic [31:0] addr;
    idx  = int'(pc[IW+1:2]);
    hit  = m_valid[idx] && (m_word[idx] == pc[17:2]);
    addr = {pc[31:2], 2'b00};
    if_valid = 1'b1;
    if_pc    = pc;
    flush    = 1'b0;
    @(negedge clk);
    if (hit) begin
      m_hits++;
      m_last = m_data[idx];
      check("hit", 32'(if_hit), 32'd1);
      check("hit_inst", if_inst, m_data[idx]);
      check("hit_nomem", 32'(mem_valid), 32'd0);
      if_valid = 1'b0;
      return;
    end
    m_misses++;
    cancel = 1'b0;
    check("miss_nohit", 32'(if_hit), 32'd0);
    check("miss_mv", 32'(mem_valid), 32'd1);
    check("miss_addr", mem_addr, addr);
    for (int c = 0; c < lat; c++) begin
      if (c == pause_at) do_pause(addr);
      if (c == flush_at) begin
        flush = 1'b1; if_valid = 1'b0; cancel = 1'b1;
      end
      @(negedge clk);
      flush = 1'b0;
      check("wait_mv", 32'(mem_valid), 32'd1);
      check("wait_hit", 32'(if_hit), 32'd0);
      check("wait_addr", mem_addr, addr);
    end
    if (flush_at == lat) begin
      flush = 1'b1; if_valid = 1'b0; cancel = 1'b1;
    end
    mem_enable = 1'b1;
    mem_din    = din;
    #1;
    check("done_mv", 32'(mem_valid), 32'd0);
    @(negedge clk);
    mem_enable = 1'b0;
    flush      = 1'b0;
    if_valid   = 1'b0;
    m_valid[idx] = 1'b1;
    m_word[idx]  = pc[17:2];
    m_data[idx]  = din;
    if (!cancel) m_last = din;
    check("fill_hit", 32'(if_hit), cancel ? 32'd0 : 32'd1);
    check("fill_inst", if_inst, m_last);
    check("fill_mv", 32'(mem_valid), 32'd0);
  endtask

  task automatic idle_flush(input logic [31:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
    flush    = 1'b1;
    @(negedge clk);
    check("iflush_hit", 32'(if_hit), 32'd0);
    check("iflush_mv", 32'(mem_valid), 32'd0);
    check("iflush_inst", if_inst, m_last);
    flush    = 1'b0;
    if_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    int          lat;
    int          mode;
    int          fat;
    int          pat;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; rdy = 1'b1; if_valid = 1'b0; if_pc = 32'h0;
    flush = 1'b0; mem_enable = 1'b0; mem_din = 32'h0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_hit", 32'(if_hit), 32'd0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_mv", 32'(mem_valid), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss, then hit.
    fetch(32'h0000_1004, 32'h0051_3023, 2, -1, -1);
    fetch(32'h0000_1004, 32'h0, 0, -1, -1);
    check_stats("after_hit");

    // Conflict on the same index.
    fetch(32'h0000_1104, 32'h1111_0104, 1, -1, -1);
    fetch(32'h0000_1004, 32'h2222_0004, 3, -1, -1);

    // Flush mid-refill, then the filled line hits.
    fetch(32'h0000_2000, 32'hDEAD_BEEF, 3, 1, -1);
    fetch(32'h0000_2000, 32'h0, 0, -1, -1);

    // Flush coincident with completion.
    fetch(32'h0000_3010, 32'h3333_3010, 2, 2, -1);
    fetch(32'h0000_3010, 32'h0, 0, -1, -1);

    // Pause during refill, then while a request waits in IDLE.
    fetch(32'h0000_1008, 32'h4444_1008, 3, -1, 1);
    rdy = 1'b0; if_valid = 1'b1; if_pc = 32'h0000_100C;
    repeat (3) begin
      @(negedge clk);
      check("pidle_hit", 32'(if_hit), 32'd0);
      check("pidle_mv", 32'(mem_valid), 32'd0);
    end
    rdy = 1'b1;
    fetch(32'h0000_100C, 32'h5555_100C, 1, -1, -1);

    // Back-to-back hits, one per cycle.
    if_valid = 1'b1;
    if_pc    = 32'h0000_1004;
    @(negedge clk);
    foreach (m_valid[k]) if (k < 0) $display("unused");
    begin
      logic [31:0] seq [4];
      seq[0] = 32'h0000_1004; seq[1] = 32'h0000_2000; seq[2] = 32'h0000_1008; seq[3] = 32'h0000_100C;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        check("b2b_hit", 32'(if_hit), 32'd1);
        check("b2b_inst", if_inst, m_data[int'(seq[k][IW+1:2])]);
        m_hits++;
        m_last = m_data[int'(seq[k][IW+1:2])];
        if (k < 3) if_pc = seq[k+1];
        else if_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_end", 32'(if_hit), 32'd0);

    // Flush in IDLE on a cached and an uncached address.
    idle_flush(32'h0000_1004);
    idle_flush(32'h0000_7000);
    check_stats("directed");

    // Async reset mid-refill, then a stray completion pulse.
    if_valid = 1'b1; if_pc = 32'h0000_4004;
    @(negedge clk);
    check("ar_mv_before", 32'(mem_valid), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("ar_mv", 32'(mem_valid), 32'd0);
    check("ar_addr", mem_addr, 32'h0);
    check("ar_inst", if_inst, 32'h0);
    model_clear();
    if_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_enable = 1'b1; mem_din = 32'hBAD0_0001;
    @(negedge clk);
    mem_enable = 1'b0;
    check("late_hit", 32'(if_hit), 32'd0);
    check("late_mv", 32'(mem_valid), 32'd0);
    fetch(32'h0000_1004, 32'h6666_1004, 1, -1, -1);

    // Randomized fetches over a small address pool to force hits and conflicts.
    for (int it = 0; it < 60; it++) begin
      pc = $urandom;
      pc[7:2]  = 6'($urandom_range(0, 7));
      pc[17:8] = 10'($urandom_range(0, 2));
      lat  = int'($urandom_range(0, 4));
      mode = int'($urandom_range(0, 4));
      fat  = (mode == 1) ? int'($urandom_range(0, lat)) : -1;
      pat  = (mode == 2 && lat > 0) ? int'($urandom_range(0, lat - 1)) : -1;
      if (mode == 3) idle_flush(pc);
      else fetch(pc, $urandom, lat, fat, pat);
    end
    check_stats("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
